wb_stage: RTL and testbench

Writeback stage of the 32I pipeline: registers the MEM-stage result, extracts and extends load data by size and byte offset, selects the writeback source and drives the register-file write port. Sits directly downstream of the memory stage, taking its combinational read data plus the ALU address, and also maintains the retired-instruction counter.

---
 rtl/wb_stage_if.sv | 43 ++++
 rtl/wb_stage.sv | 138 +++++++++++++
 tb/tb_wb_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM-stage result and pipeline controls in, register-file write port and status out.
interface wb_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) ();

    // Pipeline control
    logic             stall;
    logic             flush;

    // MEM-stage result
    logic             in_valid;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  mem_read_data;
    logic [XLEN-1:0]  pc_plus4;
    logic [2:0]       funct3;
    logic [1:0]       wb_sel;
    logic             reg_write;
    logic [4:0]       rd;

    // Register-file write port and status
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             wb_valid;
    logic             load_misaligned;
    logic [CNT_W-1:0] instret;

    // Upstream side: presents the MEM result, observes the write port
    modport master (
        output stall, flush, in_valid, alu_result, mem_read_data, pc_plus4,
               funct3, wb_sel, reg_write, rd,
        input  rf_we, rf_waddr, rf_wdata, wb_valid, load_misaligned, instret
    );

    // Writeback stage side
    modport slave (
        input  stall, flush, in_valid, alu_result, mem_read_data, pc_plus4,
               funct3, wb_sel, reg_write, rd,
        output rf_we, rf_waddr, rf_wdata, wb_valid, load_misaligned, instret
    );

endinterface

// File: rtl/wb_stage.sv
// Writeback stage: load extraction/extension, writeback source select, WB register and retired-instruction counter.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    // Combinational front end
    logic [1:0]        w_ofs;
    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_wdata;
    logic              w_misaligned;
    logic              w_load_en;
    logic              w_retire;
    logic              w_we;

    // WB register
    logic              r_wb_valid;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_load_misaligned;
    logic [CNT_W-1:0]  r_instret;

    assign w_ofs = bus.alu_result[1:0];

    // Select the addressed byte and halfword out of the returned word
    always_comb begin
        w_byte = bus.mem_read_data[7:0];
        unique case (w_ofs)
            2'd0: w_byte = bus.mem_read_data[7:0];
            2'd1: w_byte = bus.mem_read_data[15:8];
            2'd2: w_byte = bus.mem_read_data[23:16];
            2'd3: w_byte = bus.mem_read_data[31:24];
            default: w_byte = bus.mem_read_data[7:0];
        endcase
        w_half = w_ofs[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    end

    // Sign/zero-extend by load size; reserved encodings pass the raw word
    always_comb begin
        w_load_data = bus.mem_read_data;
        case (bus.funct3)
            F3_LB:   w_load_data = {{(XLEN-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            F3_LBU:  w_load_data = {{(XLEN-BYTE_W){1'b0}}, w_byte};
            F3_LH:   w_load_data = {{(XLEN-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_LHU:  w_load_data = {{(XLEN-HALF_W){1'b0}}, w_half};
            F3_LW:   w_load_data = bus.mem_read_data;
            default: w_load_data = bus.mem_read_data;
        endcase
    end

    // Misalignment only matters when the load result is actually written back
    always_comb begin
        w_misaligned = 1'b0;
        if (bus.wb_sel == WB_LOAD) begin
            case (bus.funct3)
                F3_LH, F3_LHU: w_misaligned = w_ofs[0];
                F3_LW:         w_misaligned = (w_ofs != 2'b00);
                default:       w_misaligned = 1'b0;
            endcase
        end
    end

    // Writeback source mux; 11 aliases the ALU result
    always_comb begin
        w_wdata = bus.alu_result;
        case (bus.wb_sel)
            WB_ALU:  w_wdata = bus.alu_result;
            WB_LOAD: w_wdata = w_load_data;
            WB_LINK: w_wdata = bus.pc_plus4;
            default: w_wdata = bus.alu_result;
        endcase
    end

    // Register loads only when neither flushed nor stalled; a bubble never writes
    assign w_load_en = ~bus.flush & ~bus.stall;
    assign w_we      = bus.in_valid & bus.reg_write & (bus.rd != 5'd0) & ~w_misaligned;
    assign w_retire  = w_load_en & bus.in_valid & ~w_misaligned;

    // WB register: flush clears to an all-zero bubble, stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid        <= 1'b0;
            r_rf_we           <= 1'b0;
            r_rf_waddr        <= 5'd0;
            r_rf_wdata        <= '0;
            r_load_misaligned <= 1'b0;
        end else if (bus.flush) begin
            r_wb_valid        <= 1'b0;
            r_rf_we           <= 1'b0;
            r_rf_waddr        <= 5'd0;
            r_rf_wdata        <= '0;
            r_load_misaligned <= 1'b0;
        end else if (!bus.stall) begin
            r_wb_valid        <= bus.in_valid;
            r_rf_we           <= w_we;
            r_rf_waddr        <= bus.rd;
            r_rf_wdata        <= w_wdata;
            r_load_misaligned <= bus.in_valid & w_misaligned;
        end
    end

    // Retired-instruction counter; counts once, on the edge the instruction enters WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign bus.wb_valid        = r_wb_valid;
    assign bus.rf_we           = r_rf_we;
    assign bus.rf_waddr        = r_rf_waddr;
    assign bus.rf_wdata        = r_rf_wdata;
    assign bus.load_misaligned = r_load_misaligned;
    assign bus.instret         = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic against a behavioural model.
module tb_wb_stage;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fails;

    // Reference model state
    logic        m_valid;
    logic        m_we;
    logic        m_mis;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    longint unsigned m_cnt;
    int unsigned m_cnt_s;

    wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();
    wb_stage_if #(.XLEN(32), .CNT_W(3))  bus_s ();

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow-counter instance sees identical traffic so the wrap is exercised
    wb_stage #(.XLEN(32), .CNT_W(3)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    assign bus_s.stall         = bus.stall;
    assign bus_s.flush         = bus.flush;
    assign bus_s.in_valid      = bus.in_valid;
    assign bus_s.alu_result    = bus.alu_result;
    assign bus_s.mem_read_data = bus.mem_read_data;
    assign bus_s.pc_plus4      = bus.pc_plus4;
    assign bus_s.funct3        = bus.funct3;
    assign bus_s.wb_sel        = bus.wb_sel;
    assign bus_s.reg_write     = bus.reg_write;
    assign bus_s.rd            = bus.rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
        h = (word >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b > 32'd127)   ? b - 32'd256     : b;
            3'd1:    return (h > 32'd32767) ? h - 32'h1_0000  : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [1:0] ws, input logic [31:0] addr);
        if (ws != 2'd1) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_zero(input logic clr_cnt);
        m_valid = 1'b0;
        m_we    = 1'b0;
        m_mis   = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        if (clr_cnt) begin
            m_cnt   = 0;
            m_cnt_s = 0;
        end
    endtask

    task automatic check_all();
        chk("wb_valid",        64'(bus.wb_valid),        64'(m_valid));
        chk("rf_we",           64'(bus.rf_we),           64'(m_we));
        chk("rf_waddr",        64'(bus.rf_waddr),        64'(m_waddr));
        chk("rf_wdata",        64'(bus.rf_wdata),        64'(m_wdata));
        chk("load_misaligned", 64'(bus.load_misaligned), 64'(m_mis));
        chk("instret",         bus.instret,              m_cnt);
        chk("instret_narrow",  64'(bus_s.instret),       64'(m_cnt_s));
        chk("rf_wdata_narrow", 64'(bus_s.rf_wdata),      64'(m_wdata));
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mrd,
                         input logic [31:0] pc4, input logic [2:0] f3, input logic [1:0] ws,
                         input logic rw, input logic [4:0] rd, input logic st, input logic fl);
        bus.in_valid      = v;
        bus.alu_result    = alu;
        bus.mem_read_data = mrd;
        bus.pc_plus4      = pc4;
        bus.funct3        = f3;
        bus.wb_sel        = ws;
        bus.reg_write     = rw;
        bus.rd            = rd;
        bus.stall         = st;
        bus.flush         = fl;
    endtask

    // Predict the edge from the presented inputs, clock it, then compare
    task automatic cycle();
        logic [31:0] src;
        logic        mis;
        mis = is_mis(bus.funct3, bus.wb_sel, bus.alu_result);
        case (bus.wb_sel)
            2'd1:    src = ext_load(bus.funct3, bus.alu_result, bus.mem_read_data);
            2'd2:    src = bus.pc_plus4;
            default: src = bus.alu_result;
        endcase
        if (bus.flush) begin
            model_zero(1'b0);
        end else if (!bus.stall) begin
            m_valid = bus.in_valid;
            m_mis   = bus.in_valid && mis;
            m_we    = bus.in_valid && bus.reg_write && (bus.rd != 5'd0) && !mis;
            m_waddr = bus.rd;
            m_wdata = src;
            if (bus.in_valid && !mis) begin
                m_cnt   = m_cnt + 1;
                m_cnt_s = (m_cnt_s + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges; must clear before the next edge
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        model_zero(1'b1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] la [5];
        logic [2:0]  lf [5];
        logic [31:0] le [5];
        longint unsigned c0;

        n_checks = 0;
        n_fails  = 0;
        la = '{32'h0000_2003, 32'h0000_2001, 32'h0000_2002, 32'h0000_2000, 32'h0000_2000};
        lf = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        le = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_zero(1'b1);
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ALU op
        drive(1'b1, 32'h0000_1234, $urandom, 32'd0, 3'd0, 2'd0, 1'b1, 5'd5, 1'b0, 1'b0);
        cycle();
        chk("alu_we",      64'(bus.rf_we),    64'd1);
        chk("alu_waddr",   64'(bus.rf_waddr), 64'd5);
        chk("alu_wdata",   64'(bus.rf_wdata), 64'h1234);
        chk("alu_instret", bus.instret,       64'd1);

        // Load extraction from a fixed word
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, la[i], 32'h80FF_7F01, 32'd0, lf[i], 2'd1, 1'b1, 5'(10 + i), 1'b0, 1'b0);
            cycle();
            chk("load_data", 64'(bus.rf_wdata), 64'(le[i]));
            chk("load_we",   64'(bus.rf_we),    64'd1);
        end

        // Misaligned LW and LH
        for (int i = 0; i < 2; i++) begin
            c0 = m_cnt;
            drive(1'b1, (i == 0) ? 32'h0000_1002 : 32'h0000_1001, $urandom, 32'd0,
                  (i == 0) ? 3'd2 : 3'd1, 2'd1, 1'b1, 5'd3, 1'b0, 1'b0);
            cycle();
            chk("mis_we",      64'(bus.rf_we),           64'd0);
            chk("mis_flag",    64'(bus.load_misaligned), 64'd1);
            chk("mis_valid",   64'(bus.wb_valid),        64'd1);
            chk("mis_instret", bus.instret,              c0);
        end

        // Stall holds a valid ALU op for three cycles while inputs change
        drive(1'b1, 32'hCAFE_0000, $urandom, 32'd0, 3'd0, 2'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        cycle();
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom), 1'b1,
                  5'($urandom), 1'b1, 1'b0);
            cycle();
            chk("stall_wdata",   64'(bus.rf_wdata), 64'hCAFE_0000);
            chk("stall_waddr",   64'(bus.rf_waddr), 64'd7);
            chk("stall_instret", bus.instret,       c0);
        end

        // Flush wins over stall
        drive(1'b1, $urandom, $urandom, 32'd0, 3'd0, 2'd0, 1'b1, 5'd9, 1'b1, 1'b1);
        cycle();
        chk("flush_valid", 64'(bus.wb_valid), 64'd0);
        chk("flush_we",    64'(bus.rf_we),    64'd0);

        // rd=0 still retires but never writes
        c0 = m_cnt;
        drive(1'b1, 32'h55, $urandom, 32'd0, 3'd0, 2'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        cycle();
        chk("rd0_we",      64'(bus.rf_we), 64'd0);
        chk("rd0_instret", bus.instret,    c0 + 1);

        // Link value
        drive(1'b1, $urandom, $urandom, 32'h0000_0104, 3'd0, 2'd2, 1'b1, 5'd1, 1'b0, 1'b0);
        cycle();
        chk("link_wdata", 64'(bus.rf_wdata), 64'h104);
        chk("link_we",    64'(bus.rf_we),    64'd1);

        // Reset in the middle of a stall drops the held instruction
        drive(1'b1, $urandom, $urandom, 32'd0, 3'd0, 2'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        reset_mid();

        // Randomized traffic, with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 9) < 8), $urandom, $urandom, $urandom,
                  3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            cycle();
            if ($urandom_range(0, 299) == 0) reset_mid();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
